// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD driver: FSM states, the
// field layout of the core's LCD register word, and the slow-opcode decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } lcd_state_e;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_REQ_BIT  = 11;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_DATA_MSB = 7;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear display and return home need the long execution wait on the panel.
    function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
                       (data == LCD_CMD_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; o_done flags the last cycle of a phase (count == 1).
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_count && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_hd44780_driver.sv
// Turns toggle-handshaked writes of the core's LCD register into timed HD44780
// write cycles (setup, EN pulse, hold, execution wait) with busy/ack status.
module lcd_hd44780_driver
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 25,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2500,
    parameter int EXEC_LONG_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic [31:0] o_status
);

    localparam int TMR_MAX = lcd_max(lcd_max(lcd_max(SETUP_CYC, EN_CYC),
                                             lcd_max(HOLD_CYC, EXEC_CYC)),
                                     EXEC_LONG_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETUP_LD     = TMR_W'(SETUP_CYC);
    localparam logic [TMR_W-1:0] EN_LD        = TMR_W'(EN_CYC);
    localparam logic [TMR_W-1:0] HOLD_LD      = TMR_W'(HOLD_CYC);
    localparam logic [TMR_W-1:0] EXEC_LD      = TMR_W'(EXEC_CYC);
    localparam logic [TMR_W-1:0] EXEC_LONG_LD = TMR_W'(EXEC_LONG_CYC);

    lcd_state_e  state_q;
    logic        on_q;
    logic        en_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        req_q;
    logic        ack_q;
    logic        busy_q;

    logic             pending;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_count;
    logic             tmr_done;

    logic unused_word_bits;
    assign unused_word_bits = ^{i_lcd_word[LCD_ON_BIT-1:LCD_REQ_BIT+1],
                                i_lcd_word[LCD_REQ_BIT-1:LCD_RS_BIT+1],
                                i_lcd_word[LCD_RS_BIT-1:LCD_DATA_MSB+1]};

    // A request is outstanding whenever the toggle differs from the last ack.
    assign pending = (i_lcd_word[LCD_REQ_BIT] != ack_q);

    // Each phase loads its own length on entry; the counter runs until done.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_count    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                end
            end
            ST_SETUP: begin
                tmr_load     = tmr_done;
                tmr_load_val = EN_LD;
                tmr_count    = !tmr_done;
            end
            ST_EN_HI: begin
                tmr_load     = tmr_done;
                tmr_load_val = HOLD_LD;
                tmr_count    = !tmr_done;
            end
            ST_HOLD: begin
                tmr_load     = tmr_done;
                tmr_load_val = lcd_is_long(rs_q, data_q) ? EXEC_LONG_LD : EXEC_LD;
                tmr_count    = !tmr_done;
            end
            ST_EXEC: begin
                tmr_count = 1'b1;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    lcd_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_load_val (tmr_load_val),
        .i_count    (tmr_count),
        .o_done     (tmr_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            on_q    <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            on_q <= i_lcd_word[LCD_ON_BIT];
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        rs_q    <= i_lcd_word[LCD_RS_BIT];
                        data_q  <= i_lcd_word[LCD_DATA_MSB:0];
                        req_q   <= i_lcd_word[LCD_REQ_BIT];
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        en_q    <= 1'b1;
                        state_q <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    if (tmr_done) begin
                        en_q    <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (tmr_done) begin
                        ack_q   <= req_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_busy     = busy_q;
    assign o_status   = {30'b0, ack_q, busy_q};

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver with shortened timing parameters.
module tb_lcd_hd44780_driver;

    logic        clk;
    logic        reset;
    logic [31:0] word;
    logic        lcd_on;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;
    logic        busy;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;

    lcd_hd44780_driver #(
        .SETUP_CYC     (2),
        .EN_CYC        (4),
        .HOLD_CYC      (2),
        .EXEC_CYC      (10),
        .EXEC_LONG_CYC (50)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_lcd_word (word),
        .o_lcd_on   (lcd_on),
        .o_lcd_en   (lcd_en),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_data (lcd_data),
        .o_busy     (busy),
        .o_status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects the request to be already pending; follows it to completion.
    task automatic run_txn(input string tag, input logic [7:0] exp_data, input logic exp_rs,
                           input int exp_busy);
        int busy_n   = 0;
        int en_n     = 0;
        int en_first = 0;
        int bad      = 0;
        bit done     = 0;
        step();
        check_eq({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        for (int i = 0; i < 200 && !done; i++) begin
            if (busy) begin
                busy_n++;
                if (lcd_en) begin
                    en_n++;
                    if (en_first == 0) en_first = busy_n;
                end
                if (lcd_data !== exp_data || lcd_rs !== exp_rs) bad++;
                step();
            end else begin
                done = 1;
            end
        end
        check_eq({tag, "_completed"}, {31'b0, done}, 32'd1);
        check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
        check_eq({tag, "_en_cycles"}, en_n, 32'd4);
        check_eq({tag, "_en_start"}, en_first, 32'd3);
        check_eq({tag, "_bus_stable"}, bad, 32'd0);
    endtask

    initial begin
        int busy_a;
        int bad_a;
        int en_seen;
        bit fell;

        reset = 1'b1;
        word  = 32'h0000_0800;
        repeat (5) step();
        check_eq("rst_en",     {31'b0, lcd_en}, 32'd0);
        check_eq("rst_rs",     {31'b0, lcd_rs}, 32'd0);
        check_eq("rst_rw",     {31'b0, lcd_rw}, 32'd0);
        check_eq("rst_data",   {24'b0, lcd_data}, 32'd0);
        check_eq("rst_on",     {31'b0, lcd_on}, 32'd0);
        check_eq("rst_busy",   {31'b0, busy}, 32'd0);
        check_eq("rst_status", status, 32'd0);

        // Toggle already pending at release: REQ=1 vs ack=0, data 0x00 is a normal byte.
        reset = 1'b0;
        run_txn("post_reset", 8'h00, 1'b0, 18);
        check_eq("post_reset_status", status, 32'd2);

        reset = 1'b1;
        word  = 32'h0000_0000;
        repeat (2) step();
        reset = 1'b0;
        step();
        check_eq("idle_status", status, 32'd0);

        word = 32'h0000_0A41;
        run_txn("data41", 8'h41, 1'b1, 18);
        check_eq("data41_status", status, 32'd2);

        word = 32'h0000_0001;
        run_txn("clear", 8'h01, 1'b0, 58);
        check_eq("clear_status", status, 32'd0);

        // Second request posted while the first is still busy.
        word = 32'h0000_0A55;
        step();
        check_eq("holdoff_busy_rise", {31'b0, busy}, 32'd1);
        repeat (3) step();
        word   = 32'h0000_0266;
        busy_a = 4;
        bad_a  = 0;
        fell   = 0;
        for (int i = 0; i < 100 && !fell; i++) begin
            if (busy) begin
                if (lcd_data !== 8'h55 || lcd_rs !== 1'b1) bad_a++;
                step();
                if (busy) busy_a++;
            end else begin
                fell = 1;
            end
        end
        check_eq("holdoff_first_done", {31'b0, fell}, 32'd1);
        check_eq("holdoff_first_cycles", busy_a, 32'd18);
        check_eq("holdoff_first_data", bad_a, 32'd0);
        check_eq("holdoff_ack_status", status, 32'd2);
        run_txn("holdoff_second", 8'h66, 1'b1, 18);
        check_eq("holdoff_second_status", status, 32'd0);

        // Abort in the middle of the EN pulse.
        word = 32'h0000_0A30;
        step();
        step();
        step();
        check_eq("abort_en_high", {31'b0, lcd_en}, 32'd1);
        reset = 1'b1;
        step();
        check_eq("abort_en",     {31'b0, lcd_en}, 32'd0);
        check_eq("abort_busy",   {31'b0, busy}, 32'd0);
        check_eq("abort_status", status, 32'd0);
        reset = 1'b0;
        word  = 32'h0000_0000;
        step();
        check_eq("abort_idle", {31'b0, busy}, 32'd0);

        // Power bit alone must not start a transaction.
        check_eq("on_before", {31'b0, lcd_on}, 32'd0);
        word = 32'h8000_0000;
        step();
        check_eq("on_follow", {31'b0, lcd_on}, 32'd1);
        en_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (lcd_en || busy) en_seen++;
            step();
        end
        check_eq("on_no_txn", en_seen, 32'd0);
        word = 32'h0000_0000;
        step();
        check_eq("on_off", {31'b0, lcd_on}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
